// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the staggered clock-enable sequencer.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    STARTING = 2'd1,
    ON       = 2'd2,
    STOPPING = 2'd3
  } seq_state_e;

  localparam int unsigned STAGGER_MIN = 1;

  // Ceiling log2, used to size the n_on count.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stagger_timer.sv
// Loadable down-counter; tick flags expiry while the sequencer is mid-sequence.
module stagger_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = run && (count == '0);

endmodule

// File: rtl/clk_en_sequencer.sv
// Staggered power-up / reverse power-down of N_SRC clock-source enables,
// with a thermometer-coded enable vector and registered status outputs.
module clk_en_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_STAGGER = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [CNT_W-1:0]              stagger_cfg,
  output logic [N_SRC-1:0]              en_out,
  output logic [clog2(N_SRC+1)-1:0]     n_on,
  output logic                          all_on,
  output logic                          all_off,
  output logic                          busy
);

  localparam int unsigned NW = clog2(N_SRC + 1);
  localparam logic [N_SRC-1:0] EN_FULL = '1;

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] s_lat, s_nxt, s_sel, load_val;
  logic [N_SRC-1:0] en_nxt, en_up, en_dn;
  logic [NW-1:0]    n_nxt;
  logic             run, tick, load;
  logic             accept, step_up, step_dn;

  assign s_sel = (stagger_cfg < CNT_W'(STAGGER_MIN)) ? CNT_W'(DEF_STAGGER) : stagger_cfg;
  assign en_up = (en_out << 1) | N_SRC'(1);
  assign en_dn = en_out >> 1;
  assign run   = (state == STARTING) || (state == STOPPING);

  stagger_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_nxt;
  end

  // Next state; stop has priority over start everywhere
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    case (state)
      OFF: begin
        if (start && !stop) begin
          accept  = 1'b1;
          step_up = 1'b1;
        end
      end
      STARTING: begin
        if (stop) begin
          accept  = 1'b1;
          step_dn = 1'b1;
        end else if (tick) begin
          step_up = 1'b1;
        end
      end
      ON: begin
        if (stop) begin
          accept  = 1'b1;
          step_dn = 1'b1;
        end
      end
      STOPPING: begin
        if (start && !stop) begin
          accept  = 1'b1;
          step_up = 1'b1;
        end else if (tick) begin
          step_dn = 1'b1;
        end
      end
      default: state_nxt = OFF;
    endcase
    if (step_up) state_nxt = (en_up == EN_FULL) ? ON : STARTING;
    if (step_dn) state_nxt = (en_dn == '0) ? OFF : STOPPING;
  end

  // Datapath next values: enable shift, stagger latch, timer reload
  always_comb begin
    en_nxt   = en_out;
    s_nxt    = s_lat;
    load     = 1'b0;
    load_val = s_lat - CNT_W'(1);
    if (step_up) en_nxt = en_up;
    if (step_dn) en_nxt = en_dn;
    if (accept) begin
      s_nxt    = s_sel;
      load     = 1'b1;
      load_val = s_sel - CNT_W'(1);
    end else if (step_up || step_dn) begin
      load = 1'b1;
    end
    n_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      n_nxt = n_nxt + NW'(en_nxt[i]);
    end
  end

  // Registered outputs and stagger latch
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out  <= '0;
      s_lat   <= CNT_W'(DEF_STAGGER);
      n_on    <= '0;
      all_on  <= 1'b0;
      all_off <= 1'b1;
      busy    <= 1'b0;
    end else begin
      en_out  <= en_nxt;
      s_lat   <= s_nxt;
      n_on    <= n_nxt;
      all_on  <= (state_nxt == ON) && (en_nxt == EN_FULL);
      all_off <= (state_nxt == OFF) && (en_nxt == '0);
      busy    <= (state_nxt == STARTING) || (state_nxt == STOPPING);
    end
  end

endmodule
